// File: rtl/bit_4_adder_pkg.sv
// Shared types and widths for the registered ripple-carry adder.
package bit_4_adder_pkg;

  localparam int ADD_W = 4;

  typedef logic [ADD_W-1:0] operand_t;

  typedef struct {
    operand_t sum;
    logic     c_out;
  } add_res_t;

endpackage : bit_4_adder_pkg

// File: rtl/bit_4_adder_full_adder.sv
// Single-bit full adder: one link of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/bit_4_adder.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, 1-cycle latency.
// Optional feature: define BIT_4_ADDER_OVF_EN to add the registered signed
// overflow output ovf (carry into MSB XOR carry out of MSB).
module bit_4_adder
  import bit_4_adder_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef BIT_4_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] sum_c;
  logic             msb_ci;
  logic             msb_co;

  // Each stage owns its carry-in/carry-out so the chain has no shared vector
  // feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = c_in;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci),
      .s  (sum_c[i]),
      .co (co)
    );
  end

  assign msb_ci = g_bit[WIDTH-1].ci;
  assign msb_co = g_bit[WIDTH-1].co;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             c_out_d,     c_out_q;
`ifdef BIT_4_ADDER_OVF_EN
  logic             ovf_d,       ovf_q;
`endif

  // Load a fresh result when in_valid, otherwise hold the last one; the hold
  // path also keeps unknown operands away from the outputs while idle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    out_valid_d = in_valid;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
`ifdef BIT_4_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d   = sum_c;
      c_out_d = msb_co;
`ifdef BIT_4_ADDER_OVF_EN
      ovf_d   = msb_ci ^ msb_co;
`endif
    end
  end

  // Output register stage; reset clears everything at once, discarding any
  // result that was about to be captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
`ifdef BIT_4_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge _d
      // value regardless of statement order.
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
`ifdef BIT_4_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef BIT_4_ADDER_OVF_EN
  assign ovf       = ovf_q;
`else
  // Carry into the MSB only matters for overflow detection.
  logic unused_msb_ci;
  assign unused_msb_ci = msb_ci;
`endif

endmodule : bit_4_adder

// File: tb/tb_bit_4_adder.sv
// Scoreboard bench for bit_4_adder: stimulus pushes expected results, a
// negedge monitor pops and compares whenever out_valid is high.
module tb_bit_4_adder;
  import bit_4_adder_pkg::*;

  typedef struct {
    operand_t sum;
    logic     c_out;
    logic     ovf;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     in_valid;
  operand_t a, b;
  logic     c_in;
  logic     out_valid;
  operand_t sum;
  logic     c_out;
  logic     ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bit_4_adder #(.WIDTH(ADD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
`ifdef BIT_4_ADDER_OVF_EN
    .c_out     (c_out),
    .ovf       (ovf)
`else
    .c_out     (c_out)
`endif
  );

`ifndef BIT_4_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got out_valid=1, expected no pending result");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sum", 32'(sum), 32'(e.sum));
        check("sb_c_out", 32'(c_out), 32'(e.c_out));
`ifdef BIT_4_ADDER_OVF_EN
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand set (called just after a rising edge) and push its result.
  task automatic issue(input logic [3:0] va, input logic [3:0] vb, input logic vci,
                       input logic [3:0] esum, input logic eco, input logic eovf);
    exp_t e;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    c_in     = vci;
    e.sum    = esum;
    e.c_out  = eco;
    e.ovf    = eovf;
    sb_q.push_back(e);
    sync();
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_c_out"}, 32'(c_out), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a valid operand applied: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'd5;
    b        = 4'd3;
    c_in     = 1'b0;
    #1;
    check_clear("rst_t0");
    repeat (3) begin
      @(negedge clk);
      check_clear("rst_hold");
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    sync();

    // Back-to-back stream, one result per cycle.
    issue(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    issue(4'b0000, 4'b0001, 1'b1, 4'b0010, 1'b0, 1'b0);
    issue(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    issue(4'b1001, 4'b0001, 1'b1, 4'b1011, 1'b0, 1'b0);

    // Carry-out vectors, ending with the all-ones wrap-around.
    issue(4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1, 1'b1);
    issue(4'b1101, 4'b1100, 1'b0, 4'b1001, 1'b1, 1'b0);
    issue(4'b1110, 4'b0111, 1'b1, 4'b0110, 1'b1, 1'b0);
    issue(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Idle hold with unknown operands: last result stays, out_valid drops.
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    c_in     = 1'bx;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd0);
      check("hold_sum", 32'(sum), 32'b1111);
      check("hold_c_out", 32'(c_out), 32'd1);
    end
    sync();

`ifdef BIT_4_ADDER_OVF_EN
    issue(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    issue(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    issue(4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);
`endif

    // Async reset mid-stream: result on the outputs and the one pending
    // capture are both discarded before the next edge.
    issue(4'b0101, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0);
    in_valid = 1'b1;
    a        = 4'b0001;
    b        = 4'b0001;
    c_in     = 1'b0;
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_clear("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_clear("async_rst_edge");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    sync();
    issue(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);

    // Exhaustive sweep against a behavioural sum and a sign-rule overflow.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [3:0] va, vb;
      logic       vci;
      logic [4:0] s;
      v   = 9'(i);
      va  = v[3:0];
      vb  = v[7:4];
      vci = v[8];
      s   = 5'(va) + 5'(vb) + 5'(vci);
      issue(va, vb, vci, s[3:0], s[4], (va[3] == vb[3]) && (s[3] != va[3]));
    end

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bit_4_adder
